// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Purpose  : Bundles the instruction-fetch handshake, the datapath status
//            inputs and the datapath control strobes of the multi-cycle
//            control unit.
// Modports : master - control unit side (drives fetch request and strobes)
//            slave  - instruction memory / datapath side
// Signals  : instr_req, instr_valid, instr[31:0]  fetch handshake
//            zero_flag, mem_ready                  datapath status
//            alu_control[3:0], alu_src_imm, mem_read, mem_write, reg_write,
//            mem_to_reg, pc_write, pc_src, retire, illegal_instr, mem_abort
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
    logic        instr_req;
    logic        instr_valid;
    logic [31:0] instr;
    logic        zero_flag;
    logic        mem_ready;
    logic [3:0]  alu_control;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_write;
    logic        pc_src;
    logic        retire;
    logic        illegal_instr;
    logic        mem_abort;

    modport master (
        input  instr_valid, instr, zero_flag, mem_ready,
        output instr_req, alu_control, alu_src_imm, mem_read, mem_write,
               reg_write, mem_to_reg, pc_write, pc_src, retire,
               illegal_instr, mem_abort
    );

    modport slave (
        output instr_valid, instr, zero_flag, mem_ready,
        input  instr_req, alu_control, alu_src_imm, mem_read, mem_write,
               reg_write, mem_to_reg, pc_write, pc_src, retire,
               illegal_instr, mem_abort
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : Multi-cycle control FSM for an RV32I subset (R, I-ALU, LW, SW,
//            BEQ, BNE). Fetches over a valid/ready handshake, decodes the
//            held instruction and sequences EXECUTE / MEM / WRITEBACK,
//            producing the 4-bit ALU code and the datapath strobes.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - multicycle_control_unit_if.master (fetch handshake,
//                     zero_flag / mem_ready inputs, control outputs)
// Params   : RESET_STATE - encoding of FETCH, entered on reset
//            MEM_TIMEOUT - MEM wait cycles before a forced abort, 0 = never
// Macro    : ILLEGAL_TRAP_EN - when defined, illegal encodings trap (sticky
//            illegal_instr); otherwise they retire as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter logic [2:0]  RESET_STATE = 3'd0,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    multicycle_control_unit_if.master       bus
);

    // Remaining states follow FETCH so that any RESET_STATE stays unique.
    localparam logic [2:0] S_FETCH     = RESET_STATE;
    localparam logic [2:0] S_DECODE    = RESET_STATE + 3'd1;
    localparam logic [2:0] S_EXECUTE   = RESET_STATE + 3'd2;
    localparam logic [2:0] S_MEM       = RESET_STATE + 3'd3;
    localparam logic [2:0] S_WRITEBACK = RESET_STATE + 3'd4;
    localparam logic [2:0] S_TRAP      = RESET_STATE + 3'd5;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_XOR = 4'b0100;
    localparam logic [3:0] c_ALU_SLL = 4'b0101;
    localparam logic [3:0] c_ALU_SRL = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    localparam int unsigned          c_CNT_W      = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT    = c_CNT_W'(MEM_TIMEOUT);
    localparam bit                   c_TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    // Only the control fields of IR are held here; the register and
    // immediate operand fields are consumed by the datapath directly.
    logic [6:0]         r_ir_funct7;
    logic [2:0]         r_ir_funct3;
    logic [6:0]         r_ir_opcode;
    logic [c_CNT_W-1:0] r_mem_cnt;

    logic       w_is_alu, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_illegal;
    logic [3:0] w_f3_code, w_alu_code;
    logic       w_src_imm, w_f7_zero, w_f7_alt, w_timeout;

    logic       w_instr_req, w_alu_src_imm, w_mem_read, w_mem_write;
    logic       w_reg_write, w_mem_to_reg, w_pc_write, w_pc_src;
    logic       w_retire, w_mem_abort, w_illegal_out;
    logic [3:0] w_alu_control;

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_ir_funct7 <= '0;
            r_ir_funct3 <= '0;
            r_ir_opcode <= '0;
            r_mem_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && bus.instr_valid) begin
                r_ir_funct7 <= bus.instr[31:25];
                r_ir_funct3 <= bus.instr[14:12];
                r_ir_opcode <= bus.instr[6:0];
            end
            // Counts completed MEM cycles without mem_ready; zero on entry.
            r_mem_cnt <= (r_state == S_MEM) ? r_mem_cnt + 1'b1 : '0;
        end
    end

    // Instruction classification from the held IR.
    always_comb begin : p_decode
        w_f7_zero  = (r_ir_funct7 == 7'b0000000);
        w_f7_alt   = (r_ir_funct7 == 7'b0100000);
        w_is_alu   = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_is_beq   = 1'b0;
        w_is_bne   = 1'b0;
        w_src_imm  = 1'b0;
        w_alu_code = c_ALU_ADD;
        case (r_ir_funct3)
            3'b000:  w_f3_code = c_ALU_ADD;
            3'b001:  w_f3_code = c_ALU_SLL;
            3'b010:  w_f3_code = c_ALU_SLT;
            3'b100:  w_f3_code = c_ALU_XOR;
            3'b101:  w_f3_code = c_ALU_SRL;
            3'b110:  w_f3_code = c_ALU_OR;
            3'b111:  w_f3_code = c_ALU_AND;
            default: w_f3_code = c_ALU_ADD;
        endcase
        case (r_ir_opcode)
            c_OP_R: begin
                // funct7=0100000 is only meaningful for SUB; SRA is not supported.
                w_is_alu   = (r_ir_funct3 != 3'b011) &&
                             (w_f7_zero || (w_f7_alt && r_ir_funct3 == 3'b000));
                w_alu_code = (w_f7_alt && r_ir_funct3 == 3'b000) ? c_ALU_SUB : w_f3_code;
            end
            c_OP_I: begin
                // funct7 position holds imm[11:5]; it must be zero only for shifts.
                w_is_alu   = (r_ir_funct3 != 3'b011) &&
                             (w_f7_zero || (r_ir_funct3 != 3'b001 && r_ir_funct3 != 3'b101));
                w_alu_code = w_f3_code;
                w_src_imm  = 1'b1;
            end
            c_OP_LOAD: begin
                w_is_lw   = (r_ir_funct3 == 3'b010);
                w_src_imm = 1'b1;
            end
            c_OP_STORE: begin
                w_is_sw   = (r_ir_funct3 == 3'b010);
                w_src_imm = 1'b1;
            end
            c_OP_BRANCH: begin
                w_is_beq   = (r_ir_funct3 == 3'b000);
                w_is_bne   = (r_ir_funct3 == 3'b001);
                w_alu_code = c_ALU_SUB;
            end
            default: ;
        endcase
        w_illegal = !(w_is_alu || w_is_lw || w_is_sw || w_is_beq || w_is_bne);
    end

    assign w_timeout = c_TIMEOUT_EN && (r_mem_cnt == c_TIMEOUT);

    always_comb begin : p_fsm_comb
        w_next        = r_state;
        w_instr_req   = 1'b0;
        w_alu_control = 4'b0000;
        w_alu_src_imm = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 1'b0;
        w_retire      = 1'b0;
        w_mem_abort   = 1'b0;
        if (r_state inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK}) begin
            w_alu_control = w_illegal ? c_ALU_ADD : w_alu_code;
            w_alu_src_imm = w_illegal ? 1'b0 : w_src_imm;
        end
        case (r_state)
            S_FETCH: begin
                w_instr_req = 1'b1;
                if (bus.instr_valid) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_WRITEBACK;
`endif
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (w_is_beq || w_is_bne) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = w_is_beq ? bus.zero_flag : !bus.zero_flag;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEM: begin
                // mem_ready takes priority over a coincident timeout.
                if (bus.mem_ready) begin
                    w_mem_read  = w_is_lw;
                    w_mem_write = w_is_sw;
                    if (w_is_lw) begin
                        w_next = S_WRITEBACK;
                    end else begin
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_mem_abort = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    w_mem_read  = w_is_lw;
                    w_mem_write = w_is_sw;
                end
            end
            S_WRITEBACK: begin
                // An illegal encoding reaching here retires as a NOP.
                w_reg_write  = !w_illegal;
                w_mem_to_reg = w_is_lw;
                w_pc_write   = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    // TRAP is only left by reset, so the state itself is the sticky flag.
    assign w_illegal_out = (r_state == S_TRAP);
`else
    assign w_illegal_out = 1'b0;
`endif

    assign bus.instr_req     = w_instr_req;
    assign bus.alu_control   = w_alu_control;
    assign bus.alu_src_imm   = w_alu_src_imm;
    assign bus.mem_read      = w_mem_read;
    assign bus.mem_write     = w_mem_write;
    assign bus.reg_write     = w_reg_write;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.pc_write      = w_pc_write;
    assign bus.pc_src        = w_pc_src;
    assign bus.retire        = w_retire;
    assign bus.illegal_instr = w_illegal_out;
    assign bus.mem_abort     = w_mem_abort;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Self-checking bench for multicycle_control_unit. Each scenario
//            builds a cycle-by-cycle plan (inputs plus expected outputs) from
//            an instruction-level reference model, plays it against the DUT
//            and compares every sampled cycle.
// Macro    : ILLEGAL_TRAP_EN selects the trap or NOP expectation for illegal
//            encodings, matching the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int c_MEM_TIMEOUT = 16;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_ILL = 5;
`ifdef ILLEGAL_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       instr_req;
        logic [3:0] alu_control;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_write;
        logic       pc_src;
        logic       retire;
        logic       illegal_instr;
        logic       mem_abort;
    } outs_t;

    typedef struct {
        bit          valid;
        logic [31:0] word;
        bit          ready;
        bit          zero;
        outs_t       exp;
        outs_t       care;
        string       tag;
    } cyc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    cyc_t  plan[$];
    outs_t seen[$];
    int    checks   = 0;
    int    failures = 0;
    logic [3:0] f3_alu [8];

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .RESET_STATE (3'd0),
        .MEM_TIMEOUT (c_MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void ref_decode(input logic [31:0] w, output int kind,
                                       output logic [3:0] alu, output logic imm);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        kind = K_ILL; alu = 4'd0; imm = 1'b0;
        if (op == 7'h33) begin
            if (f3 == 3'd0 && f7 == 7'h20) begin kind = K_ALU; alu = 4'd1; end
            else if (f7 == 7'h00 && f3 != 3'd3) begin kind = K_ALU; alu = f3_alu[f3]; end
        end else if (op == 7'h13) begin
            if (f3 != 3'd3 && (f7 == 7'h00 || (f3 != 3'd1 && f3 != 3'd5))) begin
                kind = K_ALU; alu = f3_alu[f3]; imm = 1'b1;
            end
        end else if (op == 7'h03 && f3 == 3'd2) begin kind = K_LW; imm = 1'b1; end
        else if (op == 7'h23 && f3 == 3'd2) begin kind = K_SW; imm = 1'b1; end
        else if (op == 7'h63 && f3 == 3'd0) begin kind = K_BEQ; alu = 4'd1; end
        else if (op == 7'h63 && f3 == 3'd1) begin kind = K_BNE; alu = 4'd1; end
    endfunction

    function automatic outs_t fetch_out();
        outs_t o = '0;
        o.instr_req = 1'b1;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.instr_req     = bus.instr_req;
        o.alu_control   = bus.alu_control;
        o.alu_src_imm   = bus.alu_src_imm;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.reg_write     = bus.reg_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.pc_write      = bus.pc_write;
        o.pc_src        = bus.pc_src;
        o.retire        = bus.retire;
        o.illegal_instr = bus.illegal_instr;
        o.mem_abort     = bus.mem_abort;
        return o;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input bit valid, input logic [31:0] word, input bit ready,
                        input bit zero, input outs_t e, input outs_t c, input string tag);
        cyc_t x;
        x.valid = valid; x.word = word; x.ready = ready; x.zero = zero;
        x.exp = e; x.care = c; x.tag = tag;
        plan.push_back(x);
    endtask

    task automatic push_idle(input string tag);
        push(1'b0, $urandom, rbit(), rbit(), fetch_out(), '1, tag);
    endtask

    // fw: idle FETCH cycles before instr_valid; mw: MEM cycle carrying
    // mem_ready (0 = never); zero: zero_flag in EXECUTE.
    task automatic plan_instr(input logic [31:0] ins, input int fw, input int mw,
                              input bit zero, input string tag);
        int kind;
        logic [3:0] alu;
        logic imm;
        outs_t base, care, e;
        ref_decode(ins, kind, alu, imm);
        for (int i = 0; i < fw; i++) push_idle(tag);
        push(1'b1, ins, rbit(), rbit(), fetch_out(), '1, tag);
        base = '0; base.alu_control = alu; base.alu_src_imm = imm;
        care = '1;
        if (kind == K_ILL) begin care.alu_control = '0; care.alu_src_imm = 1'b0; end
        push(rbit(), $urandom, rbit(), rbit(), base, care, tag);          // DECODE
        if (kind == K_ILL) begin
            if (c_TRAP) begin
                e = '0; e.illegal_instr = 1'b1;
                for (int i = 0; i < 4; i++) push(rbit(), $urandom, rbit(), rbit(), e, '1, tag);
            end else begin
                e = base; e.pc_write = 1'b1; e.retire = 1'b1;
                push(rbit(), $urandom, rbit(), rbit(), e, care, tag);
            end
            return;
        end
        if (kind == K_BEQ || kind == K_BNE) begin
            e = base; e.pc_write = 1'b1; e.retire = 1'b1;
            e.pc_src = (kind == K_BEQ) ? zero : !zero;
            push(rbit(), $urandom, rbit(), zero, e, care, tag);
            return;
        end
        push(rbit(), $urandom, rbit(), rbit(), base, care, tag);          // EXECUTE
        if (kind == K_LW || kind == K_SW) begin
            for (int k = 1; k <= c_MEM_TIMEOUT + 1; k++) begin
                e = base;
                if (mw != 0 && k == mw) begin
                    e.mem_read = (kind == K_LW); e.mem_write = (kind == K_SW);
                    if (kind == K_SW) begin e.pc_write = 1'b1; e.retire = 1'b1; end
                    push(rbit(), $urandom, 1'b1, rbit(), e, care, tag);
                    if (kind == K_SW) return;
                    break;
                end else if (k == c_MEM_TIMEOUT + 1) begin
                    e.mem_abort = 1'b1;
                    push(rbit(), $urandom, 1'b0, rbit(), e, care, tag);
                    return;
                end else begin
                    e.mem_read = (kind == K_LW); e.mem_write = (kind == K_SW);
                    push(rbit(), $urandom, 1'b0, rbit(), e, care, tag);
                end
            end
        end
        e = base; e.reg_write = 1'b1; e.mem_to_reg = (kind == K_LW);
        e.pc_write = 1'b1; e.retire = 1'b1;
        push(rbit(), $urandom, rbit(), rbit(), e, care, tag);             // WRITEBACK
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int kind;
        logic [3:0] a;
        logic m;
        do begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = w[31:25];
            endcase
            case ($urandom_range(0, 6))
                0: w = {f7, w[24:7], 7'h33};
                1: w = {f7, w[24:7], 7'h13};
                2: w = {w[31:15], (rbit() ? 3'd2 : w[14:12]), w[11:7], 7'h03};
                3: w = {w[31:15], (rbit() ? 3'd2 : w[14:12]), w[11:7], 7'h23};
                4: w = {w[31:15], 2'b00, w[12], w[11:7], 7'h63};
                5: w = {w[31:7], 7'h63};
                default: ;
            endcase
            ref_decode(w, kind, a, m);
        end while (c_TRAP && kind == K_ILL);
        return w;
    endfunction

    function automatic int gen_wait();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return $urandom_range(15, 17);
            default: return $urandom_range(1, 5);
        endcase
    endfunction

    task automatic play();
        seen.delete();
        foreach (plan[i]) begin
            @(negedge clk);
            bus.instr_valid = plan[i].valid;
            bus.instr       = plan[i].word;
            bus.mem_ready   = plan[i].ready;
            bus.zero_flag   = plan[i].zero;
            #1;
            seen.push_back(sample());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        outs_t got;
        rst_n = 1'b0;
        @(negedge clk); #1;
        got = sample();
        checks++;
        if (got !== fetch_out()) begin
            failures++; $display("FAIL reset_state: got %h required %h", got, fetch_out());
        end
        rst_n = 1'b1;
        plan.delete();
        plan_instr(32'h0050A223, 0, 0, 1'b0, "rst_sw");
        plan = plan[0:4];
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
        #2 rst_n = 1'b0;
        #1 got = sample();
        checks++;
        if (got !== fetch_out()) begin
            failures++; $display("FAIL reset_async_mem: got %h required %h", got, fetch_out());
        end
        @(negedge clk); rst_n = 1'b1; #1;
        got = sample();
        checks++;
        if (got !== fetch_out()) begin
            failures++; $display("FAIL reset_release: got %h required %h", got, fetch_out());
        end
    endtask

    task automatic test_sub();
        plan.delete();
        plan_instr(32'h402081B3, 2, 1, 1'b0, "sub");
        push_idle("sub_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_lw_sw();
        plan.delete();
        plan_instr(32'h0000A283, 0, 3, 1'b0, "lw");
        plan_instr(32'h0050A223, 0, 1, 1'b0, "sw");
        push_idle("lwsw_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        plan.delete();
        plan_instr(32'h00208463, 0, 1, 1'b1, "beq_taken");
        plan_instr(32'h00208463, 1, 1, 1'b0, "beq_not");
        plan_instr(32'h00209463, 0, 1, 1'b1, "bne_not");
        plan_instr(32'h00209463, 0, 1, 1'b0, "bne_taken");
        push_idle("br_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        plan.delete();
        plan_instr(32'h0050A223, 0, 0, 1'b0, "sw_abort");
        plan_instr(32'h0000A283, 0, 0, 1'b0, "lw_abort");
        plan_instr(32'h0050A223, 0, c_MEM_TIMEOUT, 1'b0, "sw_last_wait");
        plan_instr(32'h0000A283, 0, c_MEM_TIMEOUT + 1, 1'b0, "lw_ready_wins");
        push_idle("to_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        outs_t got;
        plan.delete();
        plan_instr(32'hFFFFFFFF, 0, 1, 1'b0, "illegal");
        if (!c_TRAP) push_idle("ill_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
        @(negedge clk); rst_n = 1'b0; #1;
        got = sample();
        checks++;
        if (got !== fetch_out()) begin
            failures++; $display("FAIL illegal_reset: got %h required %h", got, fetch_out());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        plan.delete();
        for (int n = 0; n < 12; n++) plan_instr(gen_instr(), 0, $urandom_range(1, 3), rbit(), "b2b");
        push_idle("b2b_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
    endtask

    task automatic test_random();
        plan.delete();
        for (int n = 0; n < 150; n++)
            plan_instr(gen_instr(), $urandom_range(0, 2), gen_wait(), rbit(), "rand");
        push_idle("rand_refetch");
        play();
        foreach (plan[i]) begin
            checks++;
            if ((seen[i] & plan[i].care) !== (plan[i].exp & plan[i].care)) begin
                failures++;
                $display("FAIL %s cyc %0d: got %h required %h", plan[i].tag, i, seen[i], plan[i].exp);
            end
        end
    endtask

    initial begin
        // funct3 -> ALU code table from the instruction set definition
        f3_alu[0] = 4'd0; f3_alu[1] = 4'd5; f3_alu[2] = 4'd7; f3_alu[3] = 4'd0;
        f3_alu[4] = 4'd4; f3_alu[5] = 4'd6; f3_alu[6] = 4'd3; f3_alu[7] = 4'd2;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_ready   = 1'b0;
        bus.zero_flag   = 1'b0;
        test_reset();
        test_sub();
        test_lw_sw();
        test_branch();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
